poly_mac: RTL



---
 rtl/poly_mac_pkg.sv | 22 ++
 rtl/poly_mac_stage.sv | 49 ++++
 rtl/poly_mac.sv | 121 ++++++++++++
 3 files changed

// File: rtl/poly_mac_pkg.sv
// poly_mac shared types: accumulator width helper, coefficient bank
// and commit FSM states.
package poly_mac_pkg;

    localparam int P_N  = 3;
    localparam int P_BC = 8;
    localparam int P_BT = 8;
    localparam int P_BY = 10;

    function automatic int ba_width(input int bc, input int n);
        return bc + $clog2(n + 1);
    endfunction

    typedef logic [P_N:0][P_BC-1:0] coef_bank_t;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        COMMIT
    } state_e;

endpackage

// File: rtl/poly_mac_stage.sv
// One registered Horner step: acc_out = floor(acc_in * t / 2^BT) + c.
// Each stage carries its own t and valid alongside the accumulator.
module poly_mac_stage #(
    parameter int BA = 10,
    parameter int BT = 8,
    parameter int BC = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [BA-1:0] acc_in,
    input  logic        [BT-1:0] t_in,
    input  logic                 v_in,
    input  logic signed [BC-1:0] c,
    output logic signed [BA-1:0] acc_out,
    output logic        [BT-1:0] t_out,
    output logic                 v_out
);

    logic signed [BA+BT:0] prod;
    logic signed [BA+BT:0] shf;
    logic signed [BA-1:0]  c_ext;
    logic signed [BA-1:0]  acc_d;
    logic signed [BA-1:0]  acc_q;
    logic        [BT-1:0]  t_q;
    logic                  v_q;

    // t is unsigned, so a zero sign bit keeps the product signed-correct
    assign prod  = acc_in * $signed({1'b0, t_in});
    assign shf   = prod >>> BT;
    assign c_ext = BA'(c);
    assign acc_d = shf[BA-1:0] + c_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            t_q   <= '0;
            v_q   <= 1'b0;
        end else begin
            acc_q <= acc_d;
            t_q   <= t_in;
            v_q   <= v_in;
        end
    end

    assign acc_out = acc_q;
    assign t_out   = t_q;
    assign v_out   = v_q;

endmodule

// File: rtl/poly_mac.sv
// Pipelined Horner polynomial evaluator with drained atomic coefficient commit.
// Define POLY_MAC_SAT_EN to clamp (instead of wrap) when BY < BA.
module poly_mac
    import poly_mac_pkg::*;
#(
    parameter int N  = P_N,
    parameter int BC = P_BC,
    parameter int BT = P_BT,
    parameter int BY = P_BY
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_we,
    input  logic [$clog2(N+1)-1:0]     cfg_addr,
    input  logic [BC-1:0]              cfg_data,
    input  logic                       cfg_commit,
    output logic                       commit_done,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [BT-1:0]              s_t,
    output logic                       m_valid,
    output logic [BT-1:0]              m_t,
    output logic signed [BY-1:0]       m_y
);

    localparam int BA = ba_width(BC, N);

    coef_bank_t shadow_q, shadow_d;
    coef_bank_t active_q, active_d;
    state_e     state_q, state_d;
    logic       commit_done_q;

    logic [N:0][BA-1:0] acc_c;
    logic [N:0][BT-1:0] t_c;
    logic [N:0]         v_c;
    logic               any_valid;
    logic signed [BA-1:0] acc_n;

    assign any_valid = |v_c[N:1];

    always_comb begin
        state_d = state_q;
        s_ready = 1'b0;
        unique case (state_q)
            RUN: begin
                s_ready = 1'b1;
                if (cfg_commit) state_d = DRAIN;
            end
            DRAIN: begin
                if (!any_valid) state_d = COMMIT;
            end
            COMMIT: begin
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // shadow_d feeds the copy so a write in the COMMIT cycle is included
    always_comb begin
        shadow_d = shadow_q;
        if (cfg_we && (int'(cfg_addr) <= N)) shadow_d[cfg_addr] = cfg_data;
        active_d = (state_q == COMMIT) ? shadow_d : active_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            shadow_q      <= '0;
            active_q      <= '0;
            commit_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            commit_done_q <= (state_q == COMMIT);
        end
    end

    assign commit_done = commit_done_q;

    assign acc_c[0] = BA'($signed(active_q[N]));
    assign t_c[0]   = s_t;
    assign v_c[0]   = s_valid & s_ready;

    for (genvar j = 1; j <= N; j++) begin : g_stage
        poly_mac_stage #(
            .BA (BA),
            .BT (BT),
            .BC (BC)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .acc_in  (acc_c[j-1]),
            .t_in    (t_c[j-1]),
            .v_in    (v_c[j-1]),
            .c       (active_q[N-j]),
            .acc_out (acc_c[j]),
            .t_out   (t_c[j]),
            .v_out   (v_c[j])
        );
    end

    assign acc_n   = $signed(acc_c[N]);
    assign m_valid = v_c[N];
    assign m_t     = t_c[N];

    if (BY >= BA) begin : g_ext
        assign m_y = BY'(acc_n);
    end else begin : g_narrow
`ifdef POLY_MAC_SAT_EN
        localparam logic signed [BA-1:0] YMAX = BA'((1 <<< (BY-1)) - 1);
        localparam logic signed [BA-1:0] YMIN = BA'(-(1 <<< (BY-1)));
        assign m_y = (acc_n > YMAX) ? BY'(YMAX) :
                     (acc_n < YMIN) ? BY'(YMIN) : BY'(acc_n);
`else
        assign m_y = acc_n[BY-1:0];
`endif
    end

endmodule
